// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the shift-add multiplier
//
// Contents:
//   state_t    FSM encoding: IDLE=0, BUSY=1, DONE=2
//   cnt_width  iteration counter width for a given operand width, $clog2(WIDTH)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // WIDTH is at least 2, so $clog2 never yields 0 in practice.
    // The guard only keeps the counter legal for a degenerate WIDTH.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - operand/result handshake bundle for shift_add_multiplier
//
// Parameter WIDTH: operand width; product is 2*WIDTH bits.
// Signals:
//   din_valid, din_ready       operand handshake (producer -> multiplier)
//   multiplicand, multiplier   unsigned operands A and B
//   addend                     unsigned addend C, only with SHIFT_ADD_MULT_ADDEND_EN
//   dout_valid, dout_ready     result handshake (multiplier -> consumer)
//   product                    2*WIDTH-bit result
//   busy                       multiplier in BUSY or DONE
// Modports: master = stimulus/consumer side, slave = multiplier side.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);

    logic                   din_valid;
    logic                   din_ready;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
`ifdef SHIFT_ADD_MULT_ADDEND_EN
    logic [WIDTH-1:0]       addend;
`endif
    logic                   dout_valid;
    logic                   dout_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

`ifdef SHIFT_ADD_MULT_ADDEND_EN
    modport master (
        output din_valid, multiplicand, multiplier, addend, dout_ready,
        input  din_ready, dout_valid, product, busy
    );

    modport slave (
        input  din_valid, multiplicand, multiplier, addend, dout_ready,
        output din_ready, dout_valid, product, busy
    );
`else
    modport master (
        output din_valid, multiplicand, multiplier, dout_ready,
        input  din_ready, dout_valid, product, busy
    );

    modport slave (
        input  din_valid, multiplicand, multiplier, dout_ready,
        output din_ready, dout_valid, product, busy
    );
`endif

endinterface

// File: rtl/shift_add_mult_core.sv
// rtl/shift_add_mult_core.sv - shift-add datapath: accumulator, shifted operands, iteration counter
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture operands; acc preloaded with addend
//   step           perform one multiplier-bit iteration
//   multiplicand   operand A (WIDTH)
//   multiplier     operand B (WIDTH)
//   addend         accumulator preload C (WIDTH); tie to 0 for plain A*B
//   acc_next       accumulator value after the current iteration's add (2*WIDTH)
//   last           the current iteration is the final one (cnt == WIDTH-1)
module shift_add_mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 last
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier_sh;
    logic [CW-1:0]      cnt;

    // Exposed combinationally so the final iteration's add lands in product
    // on the same edge that leaves BUSY.
    assign acc_next = mplier_sh[0] ? (acc + mcand_sh) : acc;
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            cnt       <= '0;
        end else if (load) begin
            acc       <= {{WIDTH{1'b0}}, addend};
            mcand_sh  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_sh <= multiplier;
            cnt       <= '0;
        end else if (step) begin
            acc       <= acc_next;
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            cnt       <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add multiplier, product = A*B (+C), one bit per cycle
//
// Parameter WIDTH (>= 2): operand width; product is 2*WIDTH bits.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     shift_add_multiplier_if.slave: din_valid/din_ready, multiplicand, multiplier,
//           [addend], dout_valid/dout_ready, product, busy
// Build option: SHIFT_ADD_MULT_ADDEND_EN adds the addend operand (product = A*B + C).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shift_add_multiplier_if.slave   bus
);

    state_t               state;
    logic                 din_ready_r;
    logic                 dout_valid_r;
    logic                 busy_r;
    logic [2*WIDTH-1:0]   product_r;

    logic                 load;
    logic                 step;
    logic                 last;
    logic [WIDTH-1:0]     addend_w;
    logic [2*WIDTH-1:0]   acc_next;

`ifdef SHIFT_ADD_MULT_ADDEND_EN
    assign addend_w = bus.addend;
`else
    assign addend_w = '0;
`endif

    // din_ready is registered and resets low, so the first edge after reset
    // release only raises it; operands present at release are not taken then.
    assign load = (state == IDLE) && bus.din_valid && din_ready_r;
    assign step = (state == BUSY);

    shift_add_mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .multiplicand (bus.multiplicand),
        .multiplier   (bus.multiplier),
        .addend       (addend_w),
        .acc_next     (acc_next),
        .last         (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            din_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            product_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state       <= BUSY;
                        din_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        din_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    if (last) begin
                        state        <= DONE;
                        dout_valid_r <= 1'b1;
                        product_r    <= acc_next;
                    end
                end
                DONE: begin
                    // New operands are not taken on this edge even if din_valid
                    // is high; IDLE accepts them one edge later.
                    if (bus.dout_ready) begin
                        state        <= IDLE;
                        dout_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        din_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    din_ready_r  <= 1'b0;
                    dout_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = din_ready_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = busy_r;
    assign bus.product    = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier (WIDTH=4 and WIDTH=8)
module tb_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
    shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int a, input int b, input int c);
`ifdef SHIFT_ADD_MULT_ADDEND_EN
        return 32'(a * b + c);
`else
        return 32'(a * b + (c * 0));
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // One WIDTH=4 transaction; returns with dout_valid sampled high (or timed out).
    task automatic run4(input string tag, input int a, input int b, input int c);
        int t;
        int lat;
        t = 0;
        while (!bus4.din_ready && t < 20) begin
            tick();
            t++;
        end
        check({tag, "_din_ready"}, 32'(bus4.din_ready), 32'd1);
        bus4.multiplicand = 4'(a);
        bus4.multiplier   = 4'(b);
`ifdef SHIFT_ADD_MULT_ADDEND_EN
        bus4.addend       = 4'(c);
`endif
        bus4.din_valid    = 1'b1;
        tick();
        bus4.din_valid    = 1'b0;
        sb_q.push_back(model(a, b, c));
        lat = 0;
        while (!bus4.dout_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        pop_check({tag, "_product"}, 32'(bus4.product));
    endtask

    task automatic release_check(input string tag);
        tick();
        check({tag, "_idle_din_ready"}, 32'(bus4.din_ready), 32'd1);
        check({tag, "_idle_dout_valid"}, 32'(bus4.dout_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus4.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int idx;
        int seen;
        int last_t;
        bit acc;

        rst_n = 1'b0;
        bus4.din_valid = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0; bus4.dout_ready = 1'b1;
        bus8.din_valid = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0; bus8.dout_ready = 1'b1;
`ifdef SHIFT_ADD_MULT_ADDEND_EN
        bus4.addend = '0;
        bus8.addend = '0;
`endif

        // Reset values, with din_valid already high across reset release.
        #12;
        check("rst_din_ready", 32'(bus4.din_ready), 32'd0);
        check("rst_dout_valid", 32'(bus4.dout_valid), 32'd0);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_product", 32'(bus4.product), 32'd0);
        bus4.din_valid = 1'b1;
        bus4.multiplicand = 4'd5;
        bus4.multiplier = 4'd5;
        #6;
        rst_n = 1'b1;
        tick();
        check("release_not_accepted", 32'(bus4.busy), 32'd0);
        check("release_din_ready", 32'(bus4.din_ready), 32'd1);
        bus4.din_valid = 1'b0;
        tick();

        // Basic products; din_ready returns one cycle after the result.
        run4("a3b5", 3, 5, 0);
        release_check("a3b5");
        run4("a15b15", 15, 15, 0);
        release_check("a15b15");
        run4("a0b9", 0, 9, 0);
        release_check("a0b9");
        run4("q7d2r1", 7, 2, 1);
        release_check("q7d2r1");
        run4("max_addend", 15, 15, 15);
        release_check("max_addend");

        // WIDTH=8 corner: 255*255.
        bus8.multiplicand = 8'd255;
        bus8.multiplier   = 8'd255;
        bus8.din_valid    = 1'b1;
        tick();
        bus8.din_valid    = 1'b0;
        sb_q.push_back(model(255, 255, 0));
        lat = 0;
        while (!bus8.dout_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("w8_latency", 32'(lat), 32'd8);
        pop_check("w8_product", 32'(bus8.product));

        // Backpressure: result held, din_valid pulses ignored.
        bus4.dout_ready = 1'b0;
        run4("bp", 6, 7, 0);
        for (int i = 0; i < 5; i++) begin
            bus4.multiplicand = 4'd1;
            bus4.multiplier   = 4'd1;
            bus4.din_valid    = (i % 2) == 0;
            tick();
            check("bp_hold_valid", 32'(bus4.dout_valid), 32'd1);
            check("bp_hold_product", 32'(bus4.product), 32'd42);
            check("bp_hold_din_ready", 32'(bus4.din_ready), 32'd0);
        end
        bus4.din_valid  = 1'b0;
        bus4.dout_ready = 1'b1;
        release_check("bp");
        check("bp_product_kept", 32'(bus4.product), 32'd42);
        tick();
        check("bp_pulses_ignored", 32'(bus4.busy), 32'd0);

        // Reset two cycles into BUSY discards the partial result.
        bus4.multiplicand = 4'd9;
        bus4.multiplier   = 4'd9;
        bus4.din_valid    = 1'b1;
        tick();
        bus4.din_valid    = 1'b0;
        check("mid_busy_before", 32'(bus4.busy), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout_valid", 32'(bus4.dout_valid), 32'd0);
        check("mid_rst_product", 32'(bus4.product), 32'd0);
        check("mid_rst_busy", 32'(bus4.busy), 32'd0);
        check("mid_rst_din_ready", 32'(bus4.din_ready), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        run4("after_rst", 2, 3, 0);
        release_check("after_rst");

        // Back-to-back with din_valid held high: results WIDTH+2 cycles apart.
        idx = 0;
        seen = 0;
        last_t = 0;
        bus4.multiplicand = 4'd1;
        bus4.multiplier   = 4'd1;
        bus4.din_valid    = 1'b1;
        for (int cyc = 0; cyc < 60 && seen < 3; cyc++) begin
            acc = bus4.din_valid && bus4.din_ready;
            tick();
            if (acc) begin
                sb_q.push_back(model(idx + 1, idx + 1, 0));
                idx++;
                if (idx == 3) begin
                    bus4.din_valid = 1'b0;
                end else begin
                    bus4.multiplicand = 4'(idx + 1);
                    bus4.multiplier   = 4'(idx + 1);
                end
            end
            if (bus4.dout_valid) begin
                pop_check("b2b_product", 32'(bus4.product));
                if (seen > 0) begin
                    check("b2b_gap", 32'(cyc - last_t), 32'd6);
                end
                last_t = cyc;
                seen++;
            end
        end
        bus4.din_valid = 1'b0;
        check("b2b_count", 32'(seen), 32'd3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
